freq_meter_sched: RTL and testbench
===================================

Name: freq_meter_sched

Overview:
Time-multiplexes one shared frequency-meter datapath across NCH candidate clock sources. Sits in the reference-clock domain, upstream of the meter's input clock mux.
- Selects a channel and pulses a clear to the meter.
- Discards the first DISC gate results after each switch (mux glitch, pipeline flush).
- Stores one valid result per channel in a small result file.
- Detects dead clocks by timeout.
- Round-robin over an enable mask, with a software one-shot request taking priority.

Parameters:
NCH, 4, number of multiplexed clock sources
CW, 2, channel index width (clog2(NCH))
DISC, 2, meter results discarded after each switch (0 allowed)
TMO, 32'd62500000, clk_i cycles allowed per channel before it is declared dead (2 gates of 1/8 s at 250 MHz)

Ports:
clk_i  in  1  reference clock; all logic on its rising edge
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  scheduler enable (level)
mask_i  in  NCH  channels included in the round-robin
req_i  in  1  one-shot measurement request (pulse)
req_ch_i  in  CW  channel for req_i
req_ack_o  out  1  pulse: request latched
mux_sel_o  out  CW  clock-mux select to the meter
meter_clr_o  out  1  one-cycle clear to the meter after each switch
meas_val_i  in  32  meter result in Hz, already synchronised to clk_i
meas_vld_i  in  1  one-cycle strobe per completed gate
rd_ch_i  in  CW  result-file read address
rd_freq_o  out  32  stored frequency of rd_ch_i, 1-cycle latency
rd_alive_o  out  1  stored alive flag of rd_ch_i, 1-cycle latency
upd_o  out  1  pulse: a result-file entry was written
upd_ch_o  out  CW  channel written, valid with upd_o
busy_o  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- All outputs 0, mux_sel_o = 0.
- Result file (freq and alive) all 0.
- Round-robin pointer 0, pending request cleared, FSM in IDLE.

FSM:
- IDLE:
  - Enter SWITCH if en_i and (pending request or mask_i != 0).
  - Channel choice: pending request wins; otherwise the first set bit of mask_i at or after the pointer, wrapping modulo NCH.
- SWITCH, 1 cycle:
  - Register mux_sel_o to the chosen channel.
  - Pulse meter_clr_o.
  - Load the discard counter with DISC and clear the timeout counter.
  - Go to DISCARD, or to MEAS if DISC = 0.
- DISCARD: each meas_vld_i decrements the counter; go to MEAS when it reaches 0.
- MEAS: first meas_vld_i stores meas_val_i and alive = 1 for the channel, then go to STORE.
- STORE, 1 cycle:
  - Pulse upd_o with upd_ch_o.
  - If the channel came from the round-robin, pointer = channel + 1 mod NCH.
  - If it was the pending request, clear the request and leave the pointer unchanged.
  - Return to IDLE. A back-to-back SWITCH is allowed on the next cycle.

Timeout:
- The timeout counter runs in DISCARD and MEAS.
- When it reaches TMO-1 without completion: store freq = 0 and alive = 0, then go to STORE.
- meas_vld_i in MEAS on the same cycle as the timeout: the value wins and alive = 1.

Requests:
- req_i is accepted in any state if no request is pending.
- Accepted: latch req_ch_i and pulse req_ack_o the next cycle.
- Ignored (no ack): req_i while a request is pending.
- A requested channel is served even if it is masked off.
- The request does not abort a measurement in progress.

en_i low:
- In SWITCH, DISCARD or MEAS: abort to IDLE next cycle, no file write, no upd_o.
- mux_sel_o holds its value.
- The pending request is kept.

Other boundaries:
- meas_vld_i in IDLE, SWITCH or STORE: ignored.
- mask_i changes mid-measurement: the current measurement completes; the new mask applies at the next IDLE decision.
- Reads are registered. A read of the entry written in STORE in the same cycle returns the new value one cycle later.
- All counters saturate or reload and never wrap silently.
- TMO and the timeout counter are 32 bit.

Decomposition:
- Package freq_meter_pkg:
  - FSM state enum (IDLE, SWITCH, DISCARD, MEAS, STORE).
  - Result entry struct {alive, freq[31:0]}.
  - Default TMO constant.
- One natural sub-module: freq_meter_rr_pick. Combinational first-set-bit-from-pointer search over mask_i; returns channel and found flag.

Test Plan:
- NCH = 4, DISC = 2, mask = 4'b1011, meter strobes 100/200/300 Hz per channel → channels visited 0,1,3,0. The first two strobes after each meter_clr_o are ignored, the third is stored. rd_freq_o(ch1) = 200, alive = 1.
- mask = 4'b0001, no meas_vld_i for TMO cycles → upd_o at SWITCH+1+TMO cycles, entry freq = 0, alive = 0. A later valid strobe restores alive = 1.
- During ch0 measurement, req_i with req_ch_i = 2 (masked off) → req_ack_o next cycle. After ch0 STORE, ch2 is measured, then round-robin resumes at ch1.
- Second req_i while a request is pending → no req_ack_o, first request served, second lost.
- en_i dropped in MEAS → IDLE next cycle, no upd_o, result file unchanged. en_i raised → the same channel restarts with meter_clr_o.
- Asynchronous rstn_i low in mid-DISCARD → immediately all outputs 0 and file cleared. After release, scheduling restarts from ch0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter scheduler.
//   state_t   : scheduler FSM states
//   entry_t   : one result-file entry {alive, freq}
//   TMO_DEFAULT : per-channel dead-clock timeout in reference cycles
package freq_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_DISCARD,
        ST_MEAS,
        ST_STORE
    } state_t;

    typedef struct packed {
        logic        alive;
        logic [31:0] freq;
    } entry_t;

    // Two 1/8 s gates at 250 MHz.
    localparam logic [31:0] TMO_DEFAULT = 32'd62500000;

endpackage

// File: rtl/freq_meter_sched_if.sv
// Request handshake and meter-side signals of the scheduler.
//   master : scheduler view (drives mux select, meter clear, request ack)
//   slave  : requester / meter view
interface freq_meter_sched_if #(
    parameter int CW = 2
);
    logic          req;        // one-shot measurement request
    logic [CW-1:0] req_ch;     // channel for req
    logic          req_ack;    // request latched
    logic [CW-1:0] mux_sel;    // clock-mux select to the meter
    logic          meter_clr;  // one-cycle clear after each switch
    logic [31:0]   meas_val;   // meter result in Hz
    logic          meas_vld;   // one strobe per completed gate

    modport master (
        input  req, req_ch, meas_val, meas_vld,
        output req_ack, mux_sel, meter_clr
    );

    modport slave (
        output req, req_ch, meas_val, meas_vld,
        input  req_ack, mux_sel, meter_clr
    );
endinterface

// File: rtl/freq_meter_rr_pick.sv
// Round-robin search: first set bit of mask_i at or after ptr_i, wrapping
// modulo NCH. Purely combinational.
//   mask_i  : candidate channels
//   ptr_i   : search start (must be < NCH)
//   ch_o    : selected channel (0 when none found)
//   found_o : at least one mask bit set
module freq_meter_rr_pick #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [CW-1:0]  ch_o,
    output logic           found_o
);

    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    always_comb begin
        ch_o    = '0;
        found_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NCH; i++) begin
            // ptr + i < 2*NCH, so a single conditional subtract wraps it
            sum = {1'b0, ptr_i} + (CW+1)'(i);
            if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
            idx = sum[CW-1:0];
            if (!found_o && mask_i[idx]) begin
                found_o = 1'b1;
                ch_o    = idx;
            end
        end
    end

endmodule

// File: rtl/freq_meter_sched.sv
// Time-multiplexes one frequency meter across NCH clock sources.
// Selects a channel, clears the meter, discards DISC gate results, stores one
// result per channel and flags channels whose clock produces no result within
// TMO reference cycles as dead. A pending one-shot request beats round-robin.
//   clk_i, rstn_i   : reference clock, async active-low reset
//   en_i, mask_i    : scheduler enable, round-robin channel mask
//   bus (master)    : req/req_ch/req_ack, mux_sel/meter_clr, meas_val/meas_vld
//   rd_ch_i         : result-file read address
//   rd_freq_o/alive : registered read data (1-cycle latency)
//   upd_o, upd_ch_o : result-file entry written
//   busy_o          : FSM not idle
module freq_meter_sched
    import freq_meter_pkg::*;
#(
    parameter int          NCH  = 4,
    parameter int          CW   = 2,
    parameter int          DISC = 2,
    parameter logic [31:0] TMO  = TMO_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            en_i,
    input  logic [NCH-1:0]  mask_i,
    input  logic [CW-1:0]   rd_ch_i,
    output logic [31:0]     rd_freq_o,
    output logic            rd_alive_o,
    output logic            upd_o,
    output logic [CW-1:0]   upd_ch_o,
    output logic            busy_o,
    freq_meter_sched_if.master bus
);

    localparam int DW = (DISC > 1) ? $clog2(DISC + 1) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] ptr_q;
    logic          req_pend_q;
    logic [CW-1:0] req_ch_q;
    logic          req_ack_q;
    logic          from_req_q;
    logic [CW-1:0] mux_sel_q;
    logic [DW-1:0] disc_q;
    logic [31:0]   tmo_q;
    entry_t        file_q [NCH];
    entry_t        rd_q;

    logic [CW-1:0] rr_ch;
    logic          rr_found;
    logic          start;
    logic [CW-1:0] pick_ch;
    logic          tmo_hit;
    logic          disc_done;
    logic          wr_en;
    entry_t        wr_entry;

    freq_meter_rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
        .mask_i  (mask_i),
        .ptr_i   (ptr_q),
        .ch_o    (rr_ch),
        .found_o (rr_found)
    );

    assign start     = en_i && (req_pend_q || rr_found);
    assign pick_ch   = req_pend_q ? req_ch_q : rr_ch;
    assign tmo_hit   = (tmo_q >= TMO - 32'd1);
    assign disc_done = bus.meas_vld && (disc_q == DW'(1));

    // A timeout in DISCARD stores a dead entry; in MEAS a same-cycle strobe
    // still counts as a live result. Dropping en_i suppresses any write.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = '0;
        if (en_i) begin
            if (state_q == ST_MEAS && bus.meas_vld) begin
                wr_en    = 1'b1;
                wr_entry = '{alive: 1'b1, freq: bus.meas_val};
            end else if ((state_q == ST_MEAS || state_q == ST_DISCARD) && tmo_hit) begin
                wr_en = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_SWITCH;
            ST_SWITCH: begin
                if (!en_i)          state_d = ST_IDLE;
                else if (DISC == 0) state_d = ST_MEAS;
                else                state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (!en_i)          state_d = ST_IDLE;
                else if (tmo_hit)   state_d = ST_STORE;
                else if (disc_done) state_d = ST_MEAS;
            end
            ST_MEAS: begin
                if (!en_i)                        state_d = ST_IDLE;
                else if (bus.meas_vld || tmo_hit) state_d = ST_STORE;
            end
            ST_STORE:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.meter_clr = (state_q == ST_SWITCH);
        upd_o         = (state_q == ST_STORE);
        upd_ch_o      = (state_q == ST_STORE) ? mux_sel_q : '0;
        busy_o        = (state_q != ST_IDLE);
    end

    assign bus.mux_sel = mux_sel_q;
    assign bus.req_ack = req_ack_q;
    assign rd_freq_o   = rd_q.freq;
    assign rd_alive_o  = rd_q.alive;

    // Datapath: request latch, channel/pointer, counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q      <= '0;
            req_pend_q <= 1'b0;
            req_ch_q   <= '0;
            req_ack_q  <= 1'b0;
            from_req_q <= 1'b0;
            mux_sel_q  <= '0;
            disc_q     <= '0;
            tmo_q      <= '0;
        end else begin
            req_ack_q <= 1'b0;
            if (bus.req && !req_pend_q) begin
                req_pend_q <= 1'b1;
                req_ch_q   <= bus.req_ch;
                req_ack_q  <= 1'b1;
            end
            case (state_q)
                ST_IDLE: if (start) begin
                    mux_sel_q  <= pick_ch;
                    from_req_q <= req_pend_q;
                end
                ST_SWITCH: begin
                    disc_q <= DW'(DISC);
                    tmo_q  <= '0;
                end
                ST_DISCARD, ST_MEAS: begin
                    if (tmo_q != '1) tmo_q <= tmo_q + 32'd1;
                    if (state_q == ST_DISCARD && bus.meas_vld && disc_q != '0)
                        disc_q <= disc_q - DW'(1);
                end
                ST_STORE: begin
                    // from_req_q implies the request is still pending, so the
                    // accept branch above cannot fire in the same cycle.
                    if (from_req_q)
                        req_pend_q <= 1'b0;
                    else if (mux_sel_q == CW'(NCH - 1))
                        ptr_q <= '0;
                    else
                        ptr_q <= mux_sel_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result file with registered read port
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NCH; i++) file_q[i] <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) file_q[mux_sel_q] <= wr_entry;
            rd_q <= file_q[rd_ch_i];
        end
    end

endmodule

// File: tb/tb_freq_meter_sched.sv
module tb_freq_meter_sched;
    localparam int          NCH    = 4;
    localparam int          CW     = 2;
    localparam int          DISC   = 2;
    localparam logic [31:0] TMO    = 32'd40;
    localparam int          GATE   = 5;
    localparam int          LAT_OK = GATE * (DISC + 1) + 1;  // clr -> upd, live
    localparam int          LAT_TO = 41;                     // TMO + 1

    logic            clk_i, rstn_i, en_i;
    logic [NCH-1:0]  mask_i;
    logic [CW-1:0]   rd_ch_i, stim_rd_ch, mon_rd_ch;
    logic            mon_rd_en;
    logic [31:0]     rd_freq_o;
    logic            rd_alive_o, upd_o, busy_o;
    logic [CW-1:0]   upd_ch_o;

    freq_meter_sched_if #(.CW(CW)) bus ();

    freq_meter_sched #(.NCH(NCH), .CW(CW), .DISC(DISC), .TMO(TMO)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_i       (en_i),
        .mask_i     (mask_i),
        .rd_ch_i    (rd_ch_i),
        .rd_freq_o  (rd_freq_o),
        .rd_alive_o (rd_alive_o),
        .upd_o      (upd_o),
        .upd_ch_o   (upd_ch_o),
        .busy_o     (busy_o),
        .bus        (bus)
    );

    assign rd_ch_i = mon_rd_en ? mon_rd_ch : stim_rd_ch;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [CW-1:0] ch;
        logic [31:0]   freq;
        logic          alive;
        int            lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   clr_cyc = 0;

    logic [31:0] base [NCH];
    logic        meter_on [NCH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input int ch, input int f, input int a, input int lat);
        exp_t e;
        e.ch = CW'(ch); e.freq = 32'(f); e.alive = 1'(a); e.lat = lat;
        return e;
    endfunction

    // Meter model: strobe every GATE cycles after a clear; the first DISC
    // strobes carry garbage so a missed discard shows up as a wrong value.
    int gcnt = 0, kstr = 0;
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            bus.meas_vld = 1'b0; bus.meas_val = '0; gcnt = 0; kstr = 0;
        end else if (bus.meter_clr) begin
            bus.meas_vld = 1'b0; gcnt = 0; kstr = 0;
        end else begin
            bus.meas_vld = 1'b0;
            gcnt++;
            if (gcnt == GATE) begin
                gcnt = 0;
                if (meter_on[bus.mux_sel]) begin
                    bus.meas_vld = 1'b1;
                    bus.meas_val = (kstr < DISC) ? 32'hBAD0 + 32'(kstr) : base[bus.mux_sel];
                end
                kstr++;
            end
        end
    end

    // Scoreboard monitor: every upd_o pops one expectation, checks channel and
    // latency from the preceding clear, then reads the entry back.
    logic chk_pend = 1'b0;
    exp_t chk_e;
    initial begin mon_rd_en = 1'b0; mon_rd_ch = '0; end
    always @(negedge clk_i) begin
        exp_t e;
        cyc++;
        if (chk_pend) begin
            chk("upd_rd_freq", rd_freq_o, chk_e.freq);
            chk("upd_rd_alive", 32'(rd_alive_o), 32'(chk_e.alive));
            chk_pend = 1'b0;
            mon_rd_en = 1'b0;
        end
        if (bus.meter_clr) clr_cyc = cyc;
        if (upd_o) begin
            if (q.size() == 0) begin
                chk("upd_unexpected", 32'(upd_ch_o), 32'hFFFF);
            end else begin
                e = q.pop_front();
                chk("upd_ch", 32'(upd_ch_o), 32'(e.ch));
                chk("upd_lat", 32'(cyc - clr_cyc), 32'(e.lat));
                mon_rd_ch = upd_ch_o;
                mon_rd_en = 1'b1;
                chk_e = e;
                chk_pend = 1'b1;
            end
        end
    end

    task automatic wait_drain(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk_i); #1; n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic wait_clr(input int max);
        int n = 0;
        do begin
            @(negedge clk_i); #1; n++;
        end while (!bus.meter_clr && n < max);
        if (!bus.meter_clr) chk("clr_timeout", 32'(bus.meter_clr), 32'd1);
    endtask

    task automatic rd_chk(input int ch, input int f, input int a, input string name);
        @(negedge clk_i);
        stim_rd_ch = CW'(ch);
        @(negedge clk_i); #1;
        chk({name, "_freq"}, rd_freq_o, 32'(f));
        chk({name, "_alive"}, 32'(rd_alive_o), 32'(a));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0; en_i = 1'b0; mask_i = '0; stim_rd_ch = '0;
        bus.req = 1'b0; bus.req_ch = '0;
        base[0] = 100; base[1] = 200; base[2] = 300; base[3] = 400;
        for (int i = 0; i < NCH; i++) meter_on[i] = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_mux_sel", 32'(bus.mux_sel), 0);
        chk("rst_meter_clr", 32'(bus.meter_clr), 0);
        chk("rst_upd", 32'(upd_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_req_ack", 32'(bus.req_ack), 0);
        chk("rst_rd_freq", rd_freq_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        rd_chk(1, 0, 0, "rst_file");

        // Round-robin over mask 1011: 0,1,3,0 with discard
        mask_i = 4'b1011;
        q.push_back(mk(0, 100, 1, LAT_OK));
        q.push_back(mk(1, 200, 1, LAT_OK));
        q.push_back(mk(3, 400, 1, LAT_OK));
        q.push_back(mk(0, 100, 1, LAT_OK));
        en_i = 1'b1;
        wait_drain(400);
        en_i = 1'b0;
        rd_chk(1, 200, 1, "rr_ch1");
        rd_chk(2, 0, 0, "rr_ch2");

        // Dead clock on ch0 -> timeout entry, then recovery
        meter_on[0] = 1'b0;
        mask_i = 4'b0001;
        q.push_back(mk(0, 0, 0, LAT_TO));
        en_i = 1'b1;
        wait_drain(200);
        en_i = 1'b0;
        rd_chk(0, 0, 0, "tmo_ch0");
        meter_on[0] = 1'b1;
        q.push_back(mk(0, 100, 1, LAT_OK));
        en_i = 1'b1;
        wait_drain(200);
        en_i = 1'b0;

        // Request for masked-off ch2 during ch0; second request ignored;
        // mask change mid-measurement applies at next decision
        mask_i = 4'b0001;
        q.push_back(mk(0, 100, 1, LAT_OK));
        q.push_back(mk(2, 300, 1, LAT_OK));
        q.push_back(mk(1, 200, 1, LAT_OK));
        q.push_back(mk(0, 100, 1, LAT_OK));
        en_i = 1'b1;
        wait_clr(10);
        chk("req_phase_mux", 32'(bus.mux_sel), 0);
        repeat (2) @(negedge clk_i);
        mask_i = 4'b0011;
        bus.req = 1'b1; bus.req_ch = 2'd2;
        @(negedge clk_i); #1;
        chk("req_ack", 32'(bus.req_ack), 1);
        bus.req = 1'b0;
        @(negedge clk_i); #1;
        chk("req_ack_pulse", 32'(bus.req_ack), 0);
        bus.req = 1'b1; bus.req_ch = 2'd3;
        @(negedge clk_i); #1;
        chk("req_ack_ignored", 32'(bus.req_ack), 0);
        chk("req_busy", 32'(busy_o), 1);
        bus.req = 1'b0;
        wait_drain(400);
        en_i = 1'b0;

        // en_i dropped in MEAS: abort, no write, same channel restarts
        base[1] = 250;
        en_i = 1'b1;
        wait_clr(10);
        chk("abort_ch", 32'(bus.mux_sel), 1);
        repeat (13) @(negedge clk_i);
        #1;
        chk("abort_busy_meas", 32'(busy_o), 1);
        en_i = 1'b0;
        @(negedge clk_i); #1;
        chk("abort_idle", 32'(busy_o), 0);
        chk("abort_mux_hold", 32'(bus.mux_sel), 1);
        repeat (20) @(negedge clk_i);
        rd_chk(1, 200, 1, "abort_file");
        q.push_back(mk(1, 250, 1, LAT_OK));
        en_i = 1'b1;
        wait_clr(10);
        chk("restart_ch", 32'(bus.mux_sel), 1);
        wait_drain(200);
        en_i = 1'b0;

        // Asynchronous reset mid-DISCARD (pointer is 2 here)
        en_i = 1'b1;
        wait_clr(10);
        repeat (3) @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_mux_sel", 32'(bus.mux_sel), 0);
        chk("arst_rd_freq", rd_freq_o, 0);
        chk("arst_upd", 32'(upd_o), 0);
        en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        rd_chk(1, 0, 0, "arst_file");
        mask_i = 4'b1111;
        q.push_back(mk(0, 100, 1, LAT_OK));
        en_i = 1'b1;
        wait_clr(10);
        chk("arst_restart_ch", 32'(bus.mux_sel), 0);
        wait_drain(200);
        en_i = 1'b0;

        repeat (5) @(negedge clk_i);
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
